alu_issue_queue: RTL and testbench

//  Out-of-order issue queue that feeds uops into the ALU (register-read/execute) stage.

---
 rtl/alu_issue_queue.sv | 168 ++++++++++++++++
 tb/tb_alu_issue_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Out-of-order issue queue in front of the ALU register-read/execute stage. Holds renamed ALU
//   uops until both source physical registers are ready. Entries are woken by the two ALU
//   writeback/bypass buses, and the oldest ready uop is issued into an output register.
//
//   Storage is a collapsing queue: index 0 is the oldest entry. The valid entries always occupy
//   indices 0..count-1, so the per-entry valid bit is derived from the occupancy count.
//
//   Uop layout (LSB first):
//     [0]                      valid (forced to 1 on issue)
//     [PREG_W:1]               op0 physical address
//     [2*PREG_W:PREG_W+1]      op1 physical address
//     [2*PREG_W+1]             op0 read enable
//     [2*PREG_W+2]             op1 read enable
//     [UOP_W-1:2*PREG_W+3]     remaining payload
//
// Ports
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   flush_i               synchronous flush, dominates everything except reset
//   enq_valid_i/enq_uop_i dispatch request; enq_op0_rdy_i/enq_op1_rdy_i rename-time ready bits
//   enq_ready_o           queue can accept a uop this cycle
//   wake0_*/wake1_*       ALU0/ALU1 writeback: write enable and destination register
//   issue_valid_o/issue_uop_o  output register towards the ALU; issue_ready_i accepts it
//   count_o               valid entries held in the queue (output register excluded)
module alu_issue_queue #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned PREG_W = 6,
   parameter int unsigned PAY_W  = 16,
   parameter int unsigned CNT_W  = $clog2(DEPTH + 1),
   parameter int unsigned UOP_W  = PAY_W + 2 * PREG_W + 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              enq_valid_i,
   input  logic [UOP_W-1:0]  enq_uop_i,
   input  logic              enq_op0_rdy_i,
   input  logic              enq_op1_rdy_i,
   output logic              enq_ready_o,
   input  logic              wake0_wen_i,
   input  logic [PREG_W-1:0] wake0_rd_i,
   input  logic              wake1_wen_i,
   input  logic [PREG_W-1:0] wake1_rd_i,
   output logic              issue_valid_o,
   output logic [UOP_W-1:0]  issue_uop_o,
   input  logic              issue_ready_i,
   output logic [CNT_W-1:0]  count_o
);

   logic [UOP_W-1:0] uop_q [DEPTH];
   logic [UOP_W-1:0] uop_d [DEPTH];
   logic [DEPTH-1:0] rdy0_q, rdy0_d, rdy1_q, rdy1_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             issue_valid_q, issue_valid_d;
   logic [UOP_W-1:0] issue_uop_q, issue_uop_d;

   logic [DEPTH-1:0] m0, m1, ent_rdy;
   logic             found, load_out, do_issue, enq_fire;
   logic [CNT_W-1:0] sel_idx, enq_pos;

   function automatic logic [PREG_W-1:0] op0_addr(input logic [UOP_W-1:0] u);
      return u[PREG_W:1];
   endfunction

   function automatic logic [PREG_W-1:0] op1_addr(input logic [UOP_W-1:0] u);
      return u[2*PREG_W:PREG_W+1];
   endfunction

   // Combinational wakeup match against both writeback buses in the current cycle.
   function automatic logic hit(input logic [PREG_W-1:0] a);
      return (wake0_wen_i && (wake0_rd_i == a)) || (wake1_wen_i && (wake1_rd_i == a));
   endfunction

   // Per-entry readiness and oldest-first select.
   always_comb begin
      m0      = '0;
      m1      = '0;
      ent_rdy = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         m0[i]      = hit(op0_addr(uop_q[i]));
         m1[i]      = hit(op1_addr(uop_q[i]));
         ent_rdy[i] = (CNT_W'(i) < count_q)
                      && (!uop_q[i][2*PREG_W+1] || rdy0_q[i] || m0[i])
                      && (!uop_q[i][2*PREG_W+2] || rdy1_q[i] || m1[i]);
      end
      found   = 1'b0;
      sel_idx = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (ent_rdy[i]) begin
            found   = 1'b1;
            sel_idx = CNT_W'(i);
         end
      end
   end

   assign enq_ready_o = (count_q != CNT_W'(DEPTH));
   assign load_out    = !issue_valid_q || issue_ready_i;
   assign do_issue    = load_out && found && !flush_i;
   assign enq_fire    = enq_valid_i && enq_ready_o && !flush_i;
   // An issuing entry collapses out first, so the new uop lands one slot lower.
   assign enq_pos     = count_q - CNT_W'(do_issue);

   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         uop_d[i]  = uop_q[i];
         rdy0_d[i] = rdy0_q[i] | m0[i];
         rdy1_d[i] = rdy1_q[i] | m1[i];
      end
      if (do_issue) begin
         for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            if (CNT_W'(i) >= sel_idx) begin
               uop_d[i]  = uop_q[i+1];
               rdy0_d[i] = rdy0_q[i+1] | m0[i+1];
               rdy1_d[i] = rdy1_q[i+1] | m1[i+1];
            end
         end
      end
      if (enq_fire) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (CNT_W'(i) == enq_pos) begin
               uop_d[i]  = enq_uop_i;
               rdy0_d[i] = enq_op0_rdy_i | hit(op0_addr(enq_uop_i));
               rdy1_d[i] = enq_op1_rdy_i | hit(op1_addr(enq_uop_i));
            end
         end
      end

      count_d       = count_q + CNT_W'(enq_fire) - CNT_W'(do_issue);
      issue_valid_d = issue_valid_q;
      issue_uop_d   = issue_uop_q;
      if (load_out) begin
         issue_valid_d = found;
         issue_uop_d   = found ? (uop_q[sel_idx[$clog2(DEPTH)-1:0]] | UOP_W'(1)) : '0;
      end
      if (flush_i) begin
         count_d       = '0;
         issue_valid_d = 1'b0;
         issue_uop_d   = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            uop_q[i] <= '0;
         end
         rdy0_q        <= '0;
         rdy1_q        <= '0;
         count_q       <= '0;
         issue_valid_q <= 1'b0;
         issue_uop_q   <= '0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            uop_q[i] <= uop_d[i];
         end
         rdy0_q        <= rdy0_d;
         rdy1_q        <= rdy1_d;
         count_q       <= count_d;
         issue_valid_q <= issue_valid_d;
         issue_uop_q   <= issue_uop_d;
      end
   end

   assign issue_valid_o = issue_valid_q;
   assign issue_uop_o   = issue_uop_q;
   assign count_o       = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue
//   Directed bench for alu_issue_queue (DEPTH=8, PREG_W=6, PAY_W=16). Inputs are driven 1 time
//   unit after each rising edge; outputs are sampled at that same point.
module tb_alu_issue_queue;

   localparam int unsigned UOP_W = 31;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             flush_i;
   logic             enq_valid_i;
   logic [UOP_W-1:0] enq_uop_i;
   logic             enq_op0_rdy_i, enq_op1_rdy_i;
   logic             enq_ready_o;
   logic             wake0_wen_i, wake1_wen_i;
   logic [5:0]       wake0_rd_i, wake1_rd_i;
   logic             issue_valid_o;
   logic [UOP_W-1:0] issue_uop_o;
   logic             issue_ready_i;
   logic [3:0]       count_o;

   int checks   = 0;
   int failures = 0;

   alu_issue_queue dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .enq_valid_i  (enq_valid_i),
      .enq_uop_i    (enq_uop_i),
      .enq_op0_rdy_i(enq_op0_rdy_i),
      .enq_op1_rdy_i(enq_op1_rdy_i),
      .enq_ready_o  (enq_ready_o),
      .wake0_wen_i  (wake0_wen_i),
      .wake0_rd_i   (wake0_rd_i),
      .wake1_wen_i  (wake1_wen_i),
      .wake1_rd_i   (wake1_rd_i),
      .issue_valid_o(issue_valid_o),
      .issue_uop_o  (issue_uop_o),
      .issue_ready_i(issue_ready_i),
      .count_o      (count_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [UOP_W-1:0] mk(input logic [15:0] pay, input logic [5:0] a0,
                                           input logic [5:0] a1, input logic re0,
                                           input logic re1);
      return {pay, re1, re0, a1, a0, 1'b0};
   endfunction

   // Expected output form of a stored uop: same bits with valid set.
   function automatic logic [UOP_W-1:0] iss(input logic [UOP_W-1:0] u);
      return u | UOP_W'(1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic enq(input logic [UOP_W-1:0] u, input logic r0, input logic r1);
      enq_valid_i   = 1'b1;
      enq_uop_i     = u;
      enq_op0_rdy_i = r0;
      enq_op1_rdy_i = r1;
   endtask

   logic [UOP_W-1:0] ua, ub, uc, u1;

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; enq_valid_i = 1'b0; enq_uop_i = '0;
      enq_op0_rdy_i = 1'b0; enq_op1_rdy_i = 1'b0; issue_ready_i = 1'b1;
      wake0_wen_i = 1'b0; wake0_rd_i = '0; wake1_wen_i = 1'b0; wake1_rd_i = '0;
      #2;
      check("rst_count", 32'(count_o), 0);
      check("rst_enq_ready", 32'(enq_ready_o), 1);
      check("rst_issue_valid", 32'(issue_valid_o), 0);
      check("rst_issue_uop", 32'(issue_uop_o), 0);
      tick(); tick();
      rst_i = 1'b0;

      // Single ready uop: issues one edge after enqueue.
      u1 = mk(16'h1111, 6'd3, 6'd4, 1'b1, 1'b1);
      enq(u1, 1'b1, 1'b1);
      tick();
      enq_valid_i = 1'b0;
      check("t1_count_after_enq", 32'(count_o), 1);
      check("t1_not_yet_valid", 32'(issue_valid_o), 0);
      tick();
      check("t1_issue_valid", 32'(issue_valid_o), 1);
      check("t1_issue_uop", 32'(issue_uop_o), 32'(iss(u1)));
      check("t1_count_zero", 32'(count_o), 0);
      tick();
      check("t1_drained", 32'(issue_valid_o), 0);

      // A waits on p12, younger B ready goes first; wake1 releases A.
      ua = mk(16'hAAAA, 6'd12, 6'd7, 1'b1, 1'b0);
      ub = mk(16'hBBBB, 6'd1, 6'd2, 1'b1, 1'b1);
      enq(ua, 1'b0, 1'b0);
      tick();
      enq(ub, 1'b1, 1'b1);
      tick();
      enq_valid_i = 1'b0;
      check("t2_count2", 32'(count_o), 2);
      check("t2_none_ready", 32'(issue_valid_o), 0);
      tick();
      check("t2_b_first", 32'(issue_uop_o), 32'(iss(ub)));
      check("t2_count1", 32'(count_o), 1);
      wake1_wen_i = 1'b1; wake1_rd_i = 6'd12;
      tick();
      wake1_wen_i = 1'b0;
      check("t2_a_valid", 32'(issue_valid_o), 1);
      check("t2_a_uop", 32'(issue_uop_o), 32'(iss(ua)));
      check("t2_count0", 32'(count_o), 0);
      tick();

      // Fill: output register takes P0, queue then holds P1..P8; P9 is dropped.
      issue_ready_i = 1'b0;
      for (int k = 0; k < 9; k++) begin
         enq(mk(16'(k), 6'd0, 6'd0, 1'b1, 1'b1), 1'b1, 1'b1);
         tick();
      end
      check("t3_full_count", 32'(count_o), 8);
      check("t3_enq_ready_low", 32'(enq_ready_o), 0);
      check("t3_head_held", 32'(issue_uop_o), 32'(iss(mk(16'd0, 6'd0, 6'd0, 1'b1, 1'b1))));
      enq(mk(16'd9, 6'd0, 6'd0, 1'b1, 1'b1), 1'b1, 1'b1);
      tick();
      enq_valid_i = 1'b0;
      check("t3_drop_count", 32'(count_o), 8);
      issue_ready_i = 1'b1;
      for (int k = 1; k < 9; k++) begin
         tick();
         check($sformatf("t3_order_%0d", k), 32'(issue_uop_o),
               32'(iss(mk(16'(k), 6'd0, 6'd0, 1'b1, 1'b1))));
         check($sformatf("t3_count_%0d", k), 32'(count_o), 32'(8 - k));
      end
      tick();
      check("t3_p9_dropped", 32'(issue_valid_o), 0);

      // Enqueue with same-cycle wake on op1.
      uc = mk(16'hCCCC, 6'd9, 6'd5, 1'b1, 1'b1);
      enq(uc, 1'b1, 1'b0);
      wake0_wen_i = 1'b1; wake0_rd_i = 6'd5;
      tick();
      enq_valid_i = 1'b0; wake0_wen_i = 1'b0;
      tick();
      check("t4_c_valid", 32'(issue_valid_o), 1);
      check("t4_c_uop", 32'(issue_uop_o), 32'(iss(uc)));
      tick();

      // Flush with 5 held and the output register full; concurrent enqueue ignored.
      issue_ready_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
         enq(mk(16'(16'h100 + k), 6'd0, 6'd0, 1'b1, 1'b1), 1'b1, 1'b1);
         tick();
      end
      check("t5_pre_count", 32'(count_o), 5);
      check("t5_pre_valid", 32'(issue_valid_o), 1);
      flush_i = 1'b1;
      enq(mk(16'hF00D, 6'd0, 6'd0, 1'b1, 1'b1), 1'b1, 1'b1);
      tick();
      flush_i = 1'b0; enq_valid_i = 1'b0;
      check("t5_count0", 32'(count_o), 0);
      check("t5_valid0", 32'(issue_valid_o), 0);
      check("t5_uop0", 32'(issue_uop_o), 0);
      tick();
      check("t5_nothing_enq", 32'(issue_valid_o), 0);
      check("t5_count_still0", 32'(count_o), 0);

      // Asynchronous reset between edges.
      for (int k = 0; k < 2; k++) begin
         enq(mk(16'(16'h200 + k), 6'd0, 6'd0, 1'b1, 1'b1), 1'b1, 1'b1);
         tick();
      end
      enq_valid_i = 1'b0;
      check("t6_pre_valid", 32'(issue_valid_o), 1);
      check("t6_pre_count", 32'(count_o), 1);
      #2 rst_i = 1'b1;
      #1;
      check("t6_async_count", 32'(count_o), 0);
      check("t6_async_valid", 32'(issue_valid_o), 0);
      check("t6_async_uop", 32'(issue_uop_o), 0);
      check("t6_async_enq_ready", 32'(enq_ready_o), 1);
      #2 rst_i = 1'b0;
      issue_ready_i = 1'b1;
      tick();
      check("t6_post_valid", 32'(issue_valid_o), 0);
      check("t6_post_count", 32'(count_o), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
